// File: rtl/regfile_write_arbiter.sv
// Two-requester writeback arbiter sharing the regfile's single write port (A = ALU, B = load).
// Optional write-before-read bypass outputs are enabled by defining REGFILE_WRITE_FWD_EN.
module regfile_write_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic [ADDR_WIDTH-1:0] WriteRegister,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  wEnable,
`ifdef REGFILE_WRITE_FWD_EN
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic [DATA_WIDTH-1:0] ReadData1,
    input  logic [DATA_WIDTH-1:0] ReadData2,
    output logic [DATA_WIDTH-1:0] FwdData1,
    output logic [DATA_WIDTH-1:0] FwdData2,
`endif
    output logic                  idle
);

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    logic                  a_full_q, a_full_d;
    logic [ADDR_WIDTH-1:0] a_addr_q, a_addr_d;
    logic [DATA_WIDTH-1:0] a_data_q, a_data_d;
    logic                  b_full_q, b_full_d;
    logic [ADDR_WIDTH-1:0] b_addr_q, b_addr_d;
    logic [DATA_WIDTH-1:0] b_data_q, b_data_d;
    req_e                  last_grant_q, last_grant_d;

    logic grant_a;
    logic grant_b;

    // Grant depends only on registered buffer state, so no input reaches an output combinationally.
    always_comb begin
        grant_a = a_full_q && (!b_full_q || (last_grant_q == REQ_B));
        grant_b = b_full_q && (!a_full_q || (last_grant_q == REQ_A));
    end

    assign a_ready = !a_full_q || grant_a;
    assign b_ready = !b_full_q || grant_b;
    assign idle    = !a_full_q && !b_full_q;

    // The write port is suppressed while reset is high so a discarded entry never lands in the regfile.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        WriteRegister = '0;
        WriteData     = '0;
        wEnable       = 1'b0;
        if (!reset && grant_a) begin
            WriteRegister = a_addr_q;
            WriteData     = a_data_q;
            wEnable       = (a_addr_q != '0);
        end else if (!reset && grant_b) begin
            WriteRegister = b_addr_q;
            WriteData     = b_data_q;
            wEnable       = (b_addr_q != '0);
        end
    end

    always_comb begin
        a_full_d     = a_full_q;
        a_addr_d     = a_addr_q;
        a_data_d     = a_data_q;
        b_full_d     = b_full_q;
        b_addr_d     = b_addr_q;
        b_data_d     = b_data_q;
        last_grant_d = last_grant_q;

        // Drain first; a same-edge refill below overrides the cleared flag.
        if (grant_a) begin
            a_full_d     = 1'b0;
            last_grant_d = REQ_A;
        end else if (grant_b) begin
            b_full_d     = 1'b0;
            last_grant_d = REQ_B;
        end

        if (a_valid && a_ready) begin
            a_full_d = 1'b1;
            a_addr_d = a_addr;
            a_data_d = a_data;
        end
        if (b_valid && b_ready) begin
            b_full_d = 1'b1;
            b_addr_d = b_addr;
            b_data_d = b_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            a_full_q     <= 1'b0;
            a_addr_q     <= '0;
            a_data_q     <= '0;
            b_full_q     <= 1'b0;
            b_addr_q     <= '0;
            b_data_q     <= '0;
            last_grant_q <= REQ_B;
        end else begin
            a_full_q     <= a_full_d;
            a_addr_q     <= a_addr_d;
            a_data_q     <= a_data_d;
            b_full_q     <= b_full_d;
            b_addr_q     <= b_addr_d;
            b_data_q     <= b_data_d;
            last_grant_q <= last_grant_d;
        end
    end

`ifdef REGFILE_WRITE_FWD_EN
    // Bypass the value being committed this cycle to readers of the same register.
    always_comb begin
        FwdData1 = ReadData1;
        FwdData2 = ReadData2;
        if (wEnable && (ReadRegister1 == WriteRegister)) begin
            FwdData1 = WriteData;
        end
        if (wEnable && (ReadRegister2 == WriteRegister)) begin
            FwdData2 = WriteData;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed stimulus pushes expected commits, a monitor pops them.
// Also exercises the bypass outputs when REGFILE_WRITE_FWD_EN is defined.
module tb_regfile_write_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          Clk = 1'b0;
    logic          reset;
    logic          a_valid, b_valid;
    logic          a_ready, b_ready;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;
    logic          wEnable;
    logic          idle;
`ifdef REGFILE_WRITE_FWD_EN
    logic [AW-1:0] ReadRegister1, ReadRegister2;
    logic [DW-1:0] ReadData1, ReadData2;
    logic [DW-1:0] FwdData1, FwdData2;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t     exp_q[$];
    int      checks = 0;
    int      errors = 0;
    logic [DW-1:0] regmem [32];

    always #5 Clk = ~Clk;

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clk           (Clk),
        .reset         (reset),
        .a_valid       (a_valid),
        .a_ready       (a_ready),
        .a_addr        (a_addr),
        .a_data        (a_data),
        .b_valid       (b_valid),
        .b_ready       (b_ready),
        .b_addr        (b_addr),
        .b_data        (b_data),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .wEnable       (wEnable),
`ifdef REGFILE_WRITE_FWD_EN
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .FwdData1      (FwdData1),
        .FwdData2      (FwdData2),
`endif
        .idle          (idle)
    );

    // Downstream regfile stand-in, written by whatever the DUT commits.
    always @(posedge Clk) begin
        if (wEnable) regmem[WriteRegister] <= WriteData;
    end

`ifdef REGFILE_WRITE_FWD_EN
    assign ReadData1 = regmem[ReadRegister1];
    assign ReadData2 = regmem[ReadRegister2];
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every commit seen on the write port must match the head of the expected queue.
    always @(negedge Clk) begin
        if (wEnable) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", {59'd0, WriteRegister}, 64'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("commit_addr", {59'd0, WriteRegister}, {59'd0, e.addr});
                check("commit_data", {32'd0, WriteData}, {32'd0, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wEnable"}, {63'd0, wEnable}, 64'd0);
        check({tag, "_WriteRegister"}, {59'd0, WriteRegister}, 64'd0);
        check({tag, "_WriteData"}, {32'd0, WriteData}, 64'd0);
        check({tag, "_a_ready"}, {63'd0, a_ready}, 64'd1);
        check({tag, "_b_ready"}, {63'd0, b_ready}, 64'd1);
        check({tag, "_idle"}, {63'd0, idle}, 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_idx, b_idx, a_acc, b_acc;
        for (int i = 0; i < 32; i++) regmem[i] = '0;
        a_valid = 0; b_valid = 0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
`ifdef REGFILE_WRITE_FWD_EN
        ReadRegister1 = '0; ReadRegister2 = '0;
`endif
        do_reset();
        check_reset_outputs("after_reset");

        // Single A write: committed on the next cycle, then idle.
        push(5'd2, 32'd42);
        a_valid = 1; a_addr = 5'd2; a_data = 32'd42;
        tick();
        a_valid = 0;
        check("t1_idle_busy", {63'd0, idle}, 64'd0);
        check("t1_wEnable", {63'd0, wEnable}, 64'd1);
        tick();
        check("t1_idle_after", {63'd0, idle}, 64'd1);
        check("t1_reg2", {32'd0, regmem[2]}, 64'd42);

        // Simultaneous A and B after reset: A wins because last_grant resets to B.
        do_reset();
        push(5'd3, 32'd7);
        push(5'd4, 32'd9);
        a_valid = 1; a_addr = 5'd3; a_data = 32'd7;
        b_valid = 1; b_addr = 5'd4; b_data = 32'd9;
        check("t2_a_ready", {63'd0, a_ready}, 64'd1);
        check("t2_b_ready", {63'd0, b_ready}, 64'd1);
        tick();
        a_valid = 0; b_valid = 0;
        check("t2_first_reg", {59'd0, WriteRegister}, 64'd3);
        tick();
        check("t2_second_reg", {59'd0, WriteRegister}, 64'd4);
        tick();
        check("t2_idle", {63'd0, idle}, 64'd1);
        check("t2_reg3", {32'd0, regmem[3]}, 64'd7);
        check("t2_reg4", {32'd0, regmem[4]}, 64'd9);

        // Continuous contention for 6 cycles: commits alternate A,B,...; acceptances 4 A and 3 B.
        push(5'd5, 32'd100); push(5'd20, 32'd200);
        push(5'd6, 32'd101); push(5'd21, 32'd201);
        push(5'd7, 32'd102); push(5'd22, 32'd202);
        push(5'd8, 32'd103);
        a_idx = 0; b_idx = 0; a_acc = 0; b_acc = 0;
        for (int c = 0; c < 6; c++) begin
            a_valid = 1; a_addr = 5'(5 + a_idx); a_data = 32'(100 + a_idx);
            b_valid = 1; b_addr = 5'(20 + b_idx); b_data = 32'(200 + b_idx);
            if (c > 0) check("t3_one_ready", {63'd0, a_ready ^ b_ready}, 64'd1);
            if (a_ready) begin a_idx++; a_acc++; end
            if (b_ready) begin b_idx++; b_acc++; end
            tick();
        end
        a_valid = 0; b_valid = 0;
        check("t3_a_accepts", 64'(a_acc), 64'd4);
        check("t3_b_accepts", 64'(b_acc), 64'd3);
        repeat (3) tick();
        check("t3_idle", {63'd0, idle}, 64'd1);
        check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
        check("t3_reg22", {32'd0, regmem[22]}, 64'd202);

        // Register 0: consumed without asserting wEnable.
        b_valid = 1; b_addr = 5'd0; b_data = 32'd42;
        tick();
        b_valid = 0;
        check("t4_wEnable", {63'd0, wEnable}, 64'd0);
        check("t4_idle_busy", {63'd0, idle}, 64'd0);
        tick();
        check("t4_b_ready", {63'd0, b_ready}, 64'd1);
        check("t4_idle", {63'd0, idle}, 64'd1);
        check("t4_reg0", {32'd0, regmem[0]}, 64'd0);

        // Reset while an entry is buffered: the entry is dropped.
        a_valid = 1; a_addr = 5'd12; a_data = 32'd42;
        tick();
        a_valid = 0;
        check("t5_idle_busy", {63'd0, idle}, 64'd0);
        reset = 1;
        #1;
        check("t5_wEnable_in_reset", {63'd0, wEnable}, 64'd0);
        tick();
        reset = 0;
        #1;
        check_reset_outputs("t5_after_reset");
        check("t5_reg12", {32'd0, regmem[12]}, 64'd0);

`ifdef REGFILE_WRITE_FWD_EN
        // Bypass: A commits reg 12 while reg 11 already holds 55.
        push(5'd11, 32'd55);
        a_valid = 1; a_addr = 5'd11; a_data = 32'd55;
        tick();
        a_valid = 0;
        tick();
        push(5'd12, 32'd42);
        a_valid = 1; a_addr = 5'd12; a_data = 32'd42;
        ReadRegister1 = 5'd12; ReadRegister2 = 5'd11;
        tick();
        a_valid = 0;
        check("fwd1_bypass", {32'd0, FwdData1}, 64'd42);
        check("fwd2_regfile", {32'd0, FwdData2}, 64'd55);
        tick();
        check("fwd1_after", {32'd0, FwdData1}, 64'd42);
`endif

        tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
